// File: rtl/pixel_frame_buffer_if.sv
// Controller, camera and reader signals of the pixel frame store.
// The master side is the job controller / camera / reader. The slave side is the buffer.
interface pixel_frame_buffer_if #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned IMG_H    = 2,
  parameter int unsigned IMG_W    = 2,
  parameter int unsigned CHANNELS = 3
);
  localparam int unsigned DEPTH  = IMG_H * IMG_W * CHANNELS;
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              start;
  logic [1:0]        mode;
  logic              abort;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, mode, abort, in_valid, in_data, out_ready,
    input  out_valid, out_data, out_addr, busy, done, err
  );

  modport slave (
    input  start, mode, abort, in_valid, in_data, out_ready,
    output out_valid, out_data, out_addr, busy, done, err
  );
endinterface

// File: rtl/pixel_frame_buffer.sv
// Frame store for interleaved multi-channel pixels.
// It runs WRITE, READ and CLEAR jobs over a DEPTH-word array. READ uses a registered valid/ready output.
module pixel_frame_buffer #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned IMG_H    = 2,
  parameter int unsigned IMG_W    = 2,
  parameter int unsigned CHANNELS = 3
) (
  input logic                clk,
  input logic                rst_n,
  pixel_frame_buffer_if.slave bus
);
  localparam int unsigned       DEPTH  = IMG_H * IMG_W * CHANNELS;
  localparam int unsigned       ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, CLEAR} state_e;
  typedef enum logic [1:0] {
    M_READ  = 2'b00,
    M_WRITE = 2'b01,
    M_CLEAR = 2'b10,
    M_RSVD  = 2'b11
  } mode_e;

  state_e            state_q, state_d;
  mode_e             mode;
  logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_inc, oa_inc;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              xfer;

  logic [DATA_W-1:0] mem [DEPTH];

  assign mode    = mode_e'(bus.mode);
  assign ptr_inc = ptr_q + ADDR_W'(1);
  assign oa_inc  = out_addr_q + ADDR_W'(1);
  assign xfer    = out_valid_q & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // The storage array is deliberately left out of reset so that it survives an abort or reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr_q] <= mem_wdata;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          unique case (mode)
            M_READ:  state_d = READ;
            M_WRITE: state_d = WRITE;
            M_CLEAR: state_d = CLEAR;
            M_RSVD:  state_d = IDLE;
          endcase
        end
      end
      WRITE: if (bus.abort || (bus.in_valid && ptr_q == LAST)) state_d = IDLE;
      READ:  if (bus.abort || (xfer && out_addr_q == LAST))    state_d = IDLE;
      CLEAR: if (bus.abort || ptr_q == LAST)                   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A word written or handed over on the same cycle as abort still counts. Abort only suppresses done.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = bus.in_data;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          ptr_d = '0;
          if (mode == M_READ) begin
            out_valid_d = 1'b1;
            out_data_d  = mem[0];
            out_addr_d  = '0;
          end
          if (mode == M_RSVD) err_d = 1'b1;
        end
      end
      WRITE: begin
        if (bus.in_valid) begin
          mem_we = 1'b1;
          ptr_d  = ptr_inc;
          if (ptr_q == LAST) begin
            ptr_d  = '0;
            done_d = !bus.abort;
          end
        end
        if (bus.abort) ptr_d = '0;
      end
      READ: begin
        if (xfer) begin
          if (out_addr_q == LAST) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_addr_d  = '0;
            ptr_d       = '0;
            done_d      = !bus.abort;
          end else begin
            out_data_d = mem[oa_inc];
            out_addr_d = oa_inc;
            ptr_d      = oa_inc;
          end
        end
        if (bus.abort) begin
          out_valid_d = 1'b0;
          out_data_d  = '0;
          out_addr_d  = '0;
          ptr_d       = '0;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_wdata = '0;
        ptr_d     = ptr_inc;
        if (ptr_q == LAST) begin
          ptr_d  = '0;
          done_d = !bus.abort;
        end
        if (bus.abort) ptr_d = '0;
      end
      default: ;
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Randomised bench for pixel_frame_buffer.
// It checks the buffer against an array model of the frame contents.
module tb_pixel_frame_buffer;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned IMG_H    = 2;
  localparam int unsigned IMG_W    = 2;
  localparam int unsigned CHANNELS = 3;
  localparam int unsigned DEPTH    = IMG_H * IMG_W * CHANNELS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [7:0] model [DEPTH];

  pixel_frame_buffer_if #(.DATA_W(DATA_W), .IMG_H(IMG_H), .IMG_W(IMG_W), .CHANNELS(CHANNELS)) bus ();

  pixel_frame_buffer #(.DATA_W(DATA_W), .IMG_H(IMG_H), .IMG_W(IMG_W), .CHANNELS(CHANNELS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.start     = 1'b0;
    bus.mode      = 2'b00;
    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    vectors++;
    if ({bus.out_valid, bus.busy, bus.done, bus.err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl got valid/busy/done/err=%b exp 0000",
               {bus.out_valid, bus.busy, bus.done, bus.err});
    end
    vectors++;
    if (bus.out_data !== 8'h00 || bus.out_addr !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_data got data=%h addr=%0d exp 00/0", bus.out_data, bus.out_addr);
    end
    #2 rst_n = 1'b1;
    tick();
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release got busy=%b done=%b exp 0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_write(input bit rand_data, input logic [7:0] base, input bit gaps);
    int unsigned i = 0;
    int unsigned cyc = 0;
    int unsigned dones = 0;
    logic [7:0] d;
    bus.start = 1'b1;
    bus.mode  = 2'b01;
    tick();
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL write_busy got %b exp 1", bus.busy);
    end
    while (i < DEPTH && cyc < 200) begin
      bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      d = rand_data ? 8'($urandom) : 8'(base + i);
      bus.in_data = d;
      tick();
      cyc++;
      if (bus.in_valid) begin
        model[i] = d;
        i++;
      end
      vectors++;
      if (bus.done !== (i == DEPTH) || bus.busy !== (i < DEPTH)) begin
        miscompares++;
        $display("FAIL write_progress word=%0d got done=%b busy=%b exp %b/%b",
                 i, bus.done, bus.busy, (i == DEPTH), (i < DEPTH));
      end
      if (bus.done === 1'b1) dones++;
    end
    vectors++;
    if (i < DEPTH) begin
      miscompares++;
      $display("FAIL write_timeout got %0d words exp %0d", i, DEPTH);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    tick();
    tick();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || dones != 1) begin
      miscompares++;
      $display("FAIL write_after got done=%b busy=%b pulses=%0d exp 0/0/1", bus.done, bus.busy, dones);
    end
  endtask

  // stall_mode: 0 = always ready, 1 = five-cycle stall at addr 4, 2 = random ready.
  task automatic test_read(input int unsigned stall_mode);
    int unsigned k = 0;
    int unsigned cyc = 0;
    int unsigned stall_left = 5;
    bus.start = 1'b1;
    bus.mode  = 2'b00;
    tick();
    bus.start = 1'b0;
    while (k < DEPTH && cyc < 400) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_addr !== 4'(k) || bus.out_data !== model[k]) begin
        miscompares++;
        $display("FAIL read_beat got valid=%b addr=%0d data=%h exp 1/%0d/%h",
                 bus.out_valid, bus.out_addr, bus.out_data, k, model[k]);
      end
      case (stall_mode)
        1: begin
          if (k == 4 && stall_left > 0) begin
            bus.out_ready = 1'b0;
            stall_left--;
          end else begin
            bus.out_ready = 1'b1;
          end
        end
        2: bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b1;
      endcase
      tick();
      cyc++;
      if (bus.out_ready) k++;
      if (k < DEPTH) begin
        vectors++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
          miscompares++;
          $display("FAIL read_midjob got done=%b busy=%b exp 0/1", bus.done, bus.busy);
        end
      end
    end
    vectors++;
    if (k < DEPTH) begin
      miscompares++;
      $display("FAIL read_timeout got %0d beats exp %0d", k, DEPTH);
    end
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL read_end got valid=%b data=%h done=%b busy=%b exp 0/00/1/0",
               bus.out_valid, bus.out_data, bus.done, bus.busy);
    end
    bus.out_ready = 1'b0;
    tick();
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL read_done_pulse got %b exp 0", bus.done);
    end
  endtask

  task automatic test_clear;
    bus.start = 1'b1;
    bus.mode  = 2'b10;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < int'(DEPTH); c++) begin
      vectors++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        miscompares++;
        $display("FAIL clear_run cycle=%0d got busy=%b done=%b exp 1/0", c, bus.busy, bus.done);
      end
      tick();
    end
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_last got busy=%b exp 1", bus.busy);
    end
    tick();
    vectors++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_done got done=%b busy=%b exp 1/0", bus.done, bus.busy);
    end
    for (int i = 0; i < int'(DEPTH); i++) model[i] = 8'h00;
    tick();
  endtask

  task automatic test_abort_err;
    bus.start = 1'b1;
    bus.mode  = 2'b01;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'hA0 + i);
      model[i]     = 8'(8'hA0 + i);
      tick();
    end
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA6;
    model[6]     = 8'hA6;
    tick();
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_write got busy=%b done=%b exp 0/0", bus.busy, bus.done);
    end
    tick();
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_nodone got %b exp 0", bus.done);
    end
    test_read(2);
    test_write(1'b1, 8'h00, 1'b1);
    test_read(0);
    bus.start = 1'b1;
    bus.mode  = 2'b00;
    tick();
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_read got valid=%b data=%h busy=%b done=%b exp 0/00/0/0",
               bus.out_valid, bus.out_data, bus.busy, bus.done);
    end
    bus.start = 1'b1;
    bus.mode  = 2'b11;
    tick();
    bus.start = 1'b0;
    vectors++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL err_pulse got err=%b busy=%b done=%b exp 1/0/0", bus.err, bus.busy, bus.done);
    end
    tick();
    vectors++;
    if (bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear got %b exp 0", bus.err);
    end
  endtask

  task automatic test_reset_mid_read;
    bus.start = 1'b1;
    bus.mode  = 2'b00;
    tick();
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.out_addr !== 4'd3 || bus.out_data !== model[3]) begin
      miscompares++;
      $display("FAIL midread_pos got addr=%0d data=%h exp 3/%h", bus.out_addr, bus.out_data, model[3]);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_addr !== 4'd0 || bus.out_data !== 8'h00) begin
      miscompares++;
      $display("FAIL midread_reset got valid=%b busy=%b addr=%0d data=%h exp 0/0/0/00",
               bus.out_valid, bus.busy, bus.out_addr, bus.out_data);
    end
    #1 rst_n = 1'b1;
    tick();
    test_read(0);
  endtask

  task automatic test_random_jobs;
    for (int j = 0; j < 8; j++) begin
      case ($urandom_range(0, 2))
        0: test_write(1'b1, 8'h00, 1'b1);
        1: test_read(2);
        default: begin
          test_clear();
          test_read(2);
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_write(1'b0, 8'h10, 1'b1);
    test_read(0);
    test_read(1);
    test_clear();
    test_read(0);
    test_abort_err();
    test_write(1'b0, 8'h40, 1'b0);
    test_reset_mid_read();
    test_random_jobs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
